// File: rtl/keyin_accum.sv
// Decimal key-entry block: synchronises and debounces a one-hot DIP key bank,
// accumulates digits and commits the binary value on enter. Optional backspace under KEYIN_BKSP_EN.
//   state     | meaning
//   S_WAIT    | waiting for a settled all-zero pattern (after reset or multi-hot)
//   S_IDLE    | no key down, ready to accept a one-hot press
//   S_PRESSED | digit taken, waiting for release
module keyin_accum #(
    parameter int DIGITS    = 3,
    parameter int OUT_W     = 10,
    parameter int DB_CYCLES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [9:0]       DIP,
    input  logic             enter,
    input  logic             clr,
    input  logic             bksp,
    output logic [OUT_W-1:0] datain,
    output logic             valid,
    output logic [2:0]       digit_cnt,
    output logic             ovf
);
    localparam int DB_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DB_CYCLES - 1);
    localparam logic [2:0] DIG_MAX = 3'(DIGITS);

    typedef enum logic [1:0] {S_WAIT, S_IDLE, S_PRESSED} state_t;

    state_t            state, state_nx;
    logic [9:0]        dip_s1, dip_s2, dip_last, settled;
    logic              settled_ok;
    logic [DB_W-1:0]   db_cnt;
    logic [2:0]        enter_s, clr_s;
    logic              enter_e, clr_e;
    logic              bksp_e;
    logic              strobe, one_hot;
    logic [3:0]        digit;
    logic [OUT_W-1:0]  acc;

    always_ff @(posedge clk) begin
        if (rst) begin
            dip_s1     <= '0;
            dip_s2     <= '0;
            dip_last   <= '0;
            settled    <= '0;
            settled_ok <= 1'b0;
            db_cnt     <= DB_LOAD;
            enter_s    <= '0;
            clr_s      <= '0;
            enter_e    <= 1'b0;
            clr_e      <= 1'b0;
        end else begin
            dip_s1  <= DIP;
            dip_s2  <= dip_s1;
            enter_s <= {enter_s[1:0], enter};
            clr_s   <= {clr_s[1:0], clr};
            enter_e <= enter_s[1] & ~enter_s[2];
            clr_e   <= clr_s[1] & ~clr_s[2];
            // Down-counter restarts on any change; pattern settles at terminal count.
            if (dip_s2 != dip_last) begin
                dip_last <= dip_s2;
                db_cnt   <= DB_LOAD;
            end else if (db_cnt != '0) begin
                db_cnt <= db_cnt - 1'b1;
            end else begin
                settled    <= dip_last;
                settled_ok <= 1'b1;
            end
        end
    end

`ifdef KEYIN_BKSP_EN
    logic [2:0] bksp_s;
    always_ff @(posedge clk) begin
        if (rst) begin
            bksp_s <= '0;
            bksp_e <= 1'b0;
        end else begin
            bksp_s <= {bksp_s[1:0], bksp};
            bksp_e <= bksp_s[1] & ~bksp_s[2];
        end
    end
`else
    logic unused_bksp;
    assign unused_bksp = bksp;
    assign bksp_e      = 1'b0;
`endif

    always_comb begin
        one_hot = (settled != '0) && ((settled & (settled - 10'd1)) == '0);
        digit   = 4'd0;
        for (int k = 1; k < 10; k++) begin
            if (settled[k]) digit = 4'(10 - k);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_WAIT;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        strobe   = 1'b0;
        case (state)
            S_WAIT:    if (settled_ok && settled == '0) state_nx = S_IDLE;
            S_IDLE: begin
                if (one_hot) begin
                    strobe   = 1'b1;
                    state_nx = S_PRESSED;
                end else if (settled != '0) begin
                    state_nx = S_WAIT;
                end
            end
            S_PRESSED: if (settled == '0) state_nx = S_IDLE;
            default:   state_nx = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            digit_cnt <= '0;
            ovf       <= 1'b0;
            datain    <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (clr_e) begin
                acc       <= '0;
                digit_cnt <= '0;
                ovf       <= 1'b0;
            end else if (enter_e) begin
                // An enter edge with nothing held still swallows a same-cycle strobe.
                if (digit_cnt != '0) begin
                    datain    <= acc;
                    valid     <= 1'b1;
                    acc       <= '0;
                    digit_cnt <= '0;
                    ovf       <= 1'b0;
                end
            end else if (strobe) begin
                if (digit_cnt < DIG_MAX) begin
                    acc       <= acc * OUT_W'(10) + OUT_W'(digit);
                    digit_cnt <= digit_cnt + 3'd1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (bksp_e) begin
`ifdef KEYIN_BKSP_EN
                if (digit_cnt != '0) begin
                    acc       <= acc / OUT_W'(10);
                    digit_cnt <= digit_cnt - 3'd1;
                    ovf       <= 1'b0;
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_keyin_accum.sv
// Scoreboard bench for keyin_accum: stimulus pushes expected commits, a monitor pops on valid.
module tb_keyin_accum;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] dip = '0;
    logic       enter = 1'b0, clr = 1'b0, bksp = 1'b0;
    logic [9:0] datain;
    logic       valid, ovf;
    logic [2:0] digit_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    keyin_accum dut (
        .clk(clk), .rst(rst), .DIP(dip), .enter(enter), .clr(clr), .bksp(bksp),
        .datain(datain), .valid(valid), .digit_cnt(digit_cnt), .ovf(ovf)
    );

    always #5 clk = ~clk;

    initial begin : monitor
        logic valid_d;
        int   e;
        valid_d = 1'b0;
        forever begin
            @(negedge clk);
            if (valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_valid datain=%0d expected none", datain);
                end else begin
                    e = exp_q.pop_front();
                    if (datain !== 10'(e)) begin
                        n_bad++;
                        $display("FAIL commit_value got=%0d exp=%0d", datain, e);
                    end
                end
                if (valid_d) begin
                    n_bad++;
                    $display("FAIL valid_twice got=consecutive exp=single");
                end
            end
            valid_d = valid;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic int key_bit(input int d);
        return (d == 0) ? 0 : 10 - d;
    endfunction

    task automatic press(input int d);
        dip = '0;
        dip[key_bit(d)] = 1'b1;
        cycles(30);
        dip = '0;
        cycles(30);
    endtask

    task automatic pulse_enter();
        enter = 1'b1; cycles(3); enter = 1'b0; cycles(3);
    endtask

    task automatic pulse_clr();
        clr = 1'b1; cycles(3); clr = 1'b0; cycles(3);
    endtask

    task automatic pulse_bksp();
        bksp = 1'b1; cycles(3); bksp = 1'b0; cycles(3);
    endtask

    task automatic wait_commit(input string name);
        int budget;
        budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            cycles(1);
            budget--;
        end
        check({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        cycles(3);
        check("rst_datain", int'(datain), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_cnt", int'(digit_cnt), 0);
        check("rst_ovf", int'(ovf), 0);
        rst = 1'b0;
        cycles(30);

        // 1: 4,2 -> 42
        press(4); press(2);
        check("t1_cnt_before", int'(digit_cnt), 2);
        exp_q.push_back(42);
        pulse_enter();
        wait_commit("t1");
        check("t1_cnt_after", int'(digit_cnt), 0);
        check("t1_datain", int'(datain), 42);

        // 2: overflow on fourth digit
        press(9); press(9); press(9);
        check("t2_cnt3", int'(digit_cnt), 3);
        check("t2_ovf_pre", int'(ovf), 0);
        press(5);
        check("t2_ovf_set", int'(ovf), 1);
        check("t2_cnt_hold", int'(digit_cnt), 3);
        exp_q.push_back(999);
        pulse_enter();
        wait_commit("t2");
        check("t2_ovf_clr", int'(ovf), 0);
        check("t2_datain", int'(datain), 999);

        // 3: short glitches on key 7 do not register; a long hold does, once
        for (int i = 0; i < 6; i++) begin
            dip = '0; dip[key_bit(7)] = 1'b1; cycles(3);
            dip = '0; cycles(3);
        end
        cycles(30);
        check("t3_glitch_cnt", int'(digit_cnt), 0);
        dip[key_bit(7)] = 1'b1; cycles(40); dip = '0; cycles(30);
        check("t3_hold_cnt", int'(digit_cnt), 1);
        exp_q.push_back(7);
        pulse_enter();
        wait_commit("t3");

        // 4: empty enter ignored; enter+clr together clears without commit
        pulse_enter();
        cycles(10);
        check("t4_empty_datain", int'(datain), 7);
        press(5);
        enter = 1'b1; clr = 1'b1; cycles(3);
        enter = 1'b0; clr = 1'b0; cycles(10);
        check("t4_clr_cnt", int'(digit_cnt), 0);
        check("t4_clr_datain", int'(datain), 7);
        press(0); press(0); press(7);
        check("t4_lead0_cnt", int'(digit_cnt), 3);
        exp_q.push_back(7);
        pulse_enter();
        wait_commit("t4_lead0");

        // 5: multi-hot rejected; reset while a key is held
        dip = '0; dip[key_bit(3)] = 1'b1; dip[key_bit(6)] = 1'b1;
        cycles(40); dip = '0; cycles(30);
        check("t5_multi_cnt", int'(digit_cnt), 0);
        dip[key_bit(3)] = 1'b1; cycles(30);
        check("t5_held_cnt", int'(digit_cnt), 1);
        rst = 1'b1; cycles(2); rst = 1'b0;
        cycles(40);
        check("t5_after_rst_cnt", int'(digit_cnt), 0);
        check("t5_after_rst_datain", int'(datain), 0);
        dip = '0; cycles(30);
        check("t5_release_cnt", int'(digit_cnt), 0);
        press(1);
        exp_q.push_back(1);
        pulse_enter();
        wait_commit("t5_acc_clear");

        // 6: backspace (ignored unless enabled)
        press(1); press(2); press(3);
        pulse_bksp();
`ifdef KEYIN_BKSP_EN
        check("t6_bksp_cnt", int'(digit_cnt), 2);
        press(8);
        exp_q.push_back(128);
`else
        check("t6_bksp_cnt", int'(digit_cnt), 3);
        press(8);
        check("t6_ovf", int'(ovf), 1);
        exp_q.push_back(123);
`endif
        pulse_enter();
        wait_commit("t6");
        pulse_bksp();
        check("t6_bksp_empty_cnt", int'(digit_cnt), 0);
        check("t6_bksp_empty_ovf", int'(ovf), 0);

        cycles(5);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
